// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types and sizes for the 3-digit BCD to binary converter.
// Rev    : 1.0
// ============================================================================
package bcd_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int BIN_W      = 10;
  localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

  localparam logic [BIN_W-1:0] OVF8_LIMIT = 10'd255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Reverse double-dabble correction for one BCD digit (d>=8 -> d-3).
// Rev    : 1.0
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] adj_o
);

  assign adj_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module : bcd_to_bin
// Brief  : Sequential 3-digit BCD to 10-bit binary converter (reverse double dabble).
// Rev    : 1.0
// ============================================================================
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int ITER = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic [BIN_W-1:0] bin,
  output logic             ovf8,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q;
  logic               ovf8_q;
  logic               err_q;
  logic               busy_q;
  logic               done_q;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   sh_d;
  logic               bad_digit;

  // The bcd LSB falls into the MSB of the binary shift register.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign sh_d      = {bcd_q[0], sh_q[BIN_W-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i   (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .adj_o (bcd_d[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign bad_digit = digit_invalid(hundreds) | digit_invalid(tens) | digit_invalid(ones);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf8_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (bad_digit) begin
              bin_q   <= '0;
              ovf8_q  <= 1'b0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              bcd_q   <= {hundreds, tens, ones};
              sh_q    <= '0;
              cnt_q   <= CNT_W'(ITER);
              state_q <= S_CONV;
            end
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            bin_q   <= sh_d;
            ovf8_q  <= (sh_d > OVF8_LIMIT);
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bin  = bin_q;
  assign ovf8 = ovf8_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_to_bin
// Brief  : Self-checking bench for bcd_to_bin against an arithmetic reference.
// Rev    : 1.0
// ============================================================================
module tb_bcd_to_bin;

  localparam int ITER = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] hundreds, tens, ones;
  logic [9:0] bin;
  logic       ovf8, err, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_bin #(.ITER(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .ovf8     (ovf8),
    .err      (err),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion, checked against decimal arithmetic on the digits.
  task automatic run(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                     input bit scramble, input bit repulse);
    bit exp_err;
    int exp_bin, exp_cyc, done_at, busy_n, done_n;
    exp_err = (h > 9) || (t > 9) || (o > 9);
    exp_bin = exp_err ? 0 : int'(h) * 100 + int'(t) * 10 + int'(o);
    exp_cyc = exp_err ? 1 : ITER + 1;
    done_at = 0; busy_n = 0; done_n = 0;
    hundreds = h; tens = t; ones = o; start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
    end
    for (int k = 1; k <= exp_cyc + 2; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = k;
        chk("bin", 32'(bin), 32'(exp_bin));
        chk("ovf8", 32'(ovf8), 32'(exp_bin > 255));
        chk("err", 32'(err), 32'(exp_err));
      end
      if (repulse && k == 4) begin
        start = 1'b1; hundreds = 4'd8; tens = 4'd8; ones = 4'd8;
      end
      if (repulse && k == 5) start = 1'b0;
      tick();
    end
    chk("latency", 32'(done_at), 32'(exp_cyc));
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(exp_cyc));
    chk("bin_hold", 32'(bin), 32'(exp_bin));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; hundreds = '0; tens = '0; ones = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_flags", {28'd0, ovf8, err, busy, done}, 32'd0);

    run(4'd1, 4'd7, 4'd0, 1'b0, 1'b0);
    run(4'd2, 4'd5, 4'd5, 1'b0, 1'b0);
    run(4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    run(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    run(4'd0, 4'd1, 4'd5, 1'b0, 1'b0);
    run(4'd3, 4'hA, 4'd2, 1'b0, 1'b0);
    run(4'd6, 4'd4, 4'd3, 1'b1, 1'b1);

    // Abort mid-conversion: no done, outputs cleared.
    hundreds = 4'd7; tens = 4'd7; ones = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) done_seen++;
      tick();
    end
    chk("abort_done", 32'(done_seen), 32'd0);
    chk("abort_bin", 32'(bin), 32'd0);
    chk("abort_flags", {28'd0, ovf8, err, busy, done}, 32'd0);
    run(4'd2, 4'd3, 4'd1, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    hundreds = 4'd1; tens = 4'd2; ones = 4'd3; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_vs_start_idle", {30'd0, busy, done}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rh, rt, ro;
      rh = 4'($urandom_range(0, 9));
      rt = 4'($urandom_range(0, 9));
      ro = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) ro = 4'($urandom_range(10, 15));
      run(rh, rt, ro, 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter ITER, default 10, meaning the number of shift iterations (equal to the binary output width).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, a request to convert the current digits; sampled only in IDLE.
REQ-005 SHALL have port hundreds, input, 4, the BCD hundreds digit.
REQ-006 SHALL have port tens, input, 4, the BCD tens digit.
REQ-007 SHALL have port ones, input, 4, the BCD ones digit.
REQ-008 SHALL have port bin, output, 10, the binary result, range 0..999.
REQ-009 SHALL have port ovf8, output, 1, set when the result exceeds 255 (does not fit the 8-bit forward converter).
REQ-010 SHALL have port err, output, 1, set when any input digit is greater than 9.
REQ-011 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse marking bin/ovf8/err valid.

Function
REQ-013 SHALL implement FSM states IDLE, CONV and DONE.
REQ-014 In IDLE with start=1 at edge E0, SHALL capture {hundreds,tens,ones} into a 12-bit BCD register, clear the 10-bit shift register, load the iteration counter with ITER and enter CONV.
REQ-015 In IDLE at edge E0, if any digit is greater than 9, SHALL enter DONE directly with err=1, bin=0 and ovf8=0.
REQ-016 Each CONV edge SHALL perform one reverse double-dabble step:
- shift {bcd,sh} right by 1, with the bcd LSB moving into the sh MSB;
- then, for each 4-bit digit of bcd that is 8 or greater, subtract 3;
- then decrement the counter.
REQ-017 After the ITER-th CONV edge (E10 for the default ITER), SHALL register bin=sh and ovf8=(sh>255), set err=0 and enter DONE.
REQ-018 done SHALL be high for exactly one cycle while in DONE, after which the FSM SHALL return to IDLE.
REQ-019 Latency for valid input SHALL be: done observed high in the cycle following edge E10; input-to-done is 11 edges including the start edge.
REQ-020 busy SHALL be high in CONV and DONE and low in IDLE.
REQ-021 start SHALL be ignored outside IDLE; a start held high continuously SHALL begin a new conversion on the first IDLE cycle.
REQ-022 Input digits SHALL be sampled only at the start edge; later changes to the inputs SHALL have no effect on the conversion in progress.
REQ-023 bin, ovf8 and err SHALL hold their values from the last DONE until the next DONE.
REQ-024 All arithmetic SHALL be unsigned; each digit adjust SHALL be 4-bit with no borrow into the neighbouring digit.

Reset
REQ-025 When rst=1 at a clock edge, SHALL force state=IDLE, bin=0, ovf8=0, err=0, busy=0, done=0 and clear all internal registers.
REQ-026 Reset asserted during CONV or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 If rst and start are both high at the same edge, rst SHALL win.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the FSM state enum, NUM_DIGITS=3, DIGIT_W=4 and BIN_W=10.
REQ-029 A combinational sub-module bcd_digit_adj SHALL output (d>=8 ? d-3 : d) for one digit; bcd_to_bin SHALL instantiate it once per digit.

Verification
REQ-030 SHALL cover: h=1, t=7, o=0 with a start pulse -> done after 11 edges; bin=170 (00_1010_1010), ovf8=0, err=0.
REQ-031 SHALL cover: digits 2,5,5 -> bin=255, ovf8=0; then digits 9,9,9 -> bin=999 (0x3E7), ovf8=1.
REQ-032 SHALL cover: digits 0,0,0 -> bin=0; then digits 0,1,5 -> bin=15; busy high for exactly 11 cycles per conversion.
REQ-033 SHALL cover: t=4'hA with start -> done on the next cycle, err=1, bin=0, ovf8=0.
REQ-034 SHALL cover: rst pulsed 5 cycles after start -> no done pulse, all outputs 0; the next conversion (2,3,1) -> bin=231.
REQ-035 SHALL cover: start re-pulsed mid-CONV with new digits -> ignored; the result matches the originally sampled digits.
